pipe_destination_scoreboard: RTL and testbench

//  Parametrised destination tracker for the in-order core pipeline. Takes decoded
//  (destination flag, destination register) per issued instruction and keeps them
//  in a DEPTH-stage shadow of the execute/memory/writeback stages. Flags RAW hazards
//  for up to two source operands, reports retiring writes, and supports branch flush.

---
 rtl/pipe_destination_scoreboard_if.sv | 44 ++++
 rtl/pipe_destination_scoreboard.sv | 107 ++++++++++
 tb/tb_pipe_destination_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_destination_scoreboard_if.sv
// Decode/issue <-> destination scoreboard bundle.
// master: decode/issue side (drives instruction info, reads hazard results).
// slave : the scoreboard itself.
interface pipe_destination_scoreboard_if #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 3
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);

  logic              i_advance;
  logic              i_issue_valid;
  logic              i_dst_flag;
  logic [REG_AW-1:0] i_dst;
  logic              i_flush;
  logic              i_src_a_used;
  logic [REG_AW-1:0] i_src_a;
  logic              i_src_b_used;
  logic [REG_AW-1:0] i_src_b;
  logic              o_hazard_a;
  logic              o_hazard_b;
  logic              o_stall;
  logic              o_retire_valid;
  logic [REG_AW-1:0] o_retire_dst;
  logic [CW-1:0]     o_pending;
  logic              o_fwd_hit_a;
  logic [SW-1:0]     o_fwd_sel_a;
  logic              o_fwd_hit_b;
  logic [SW-1:0]     o_fwd_sel_b;

  modport master (
    output i_advance, i_issue_valid, i_dst_flag, i_dst, i_flush,
           i_src_a_used, i_src_a, i_src_b_used, i_src_b,
    input  o_hazard_a, o_hazard_b, o_stall, o_retire_valid, o_retire_dst,
           o_pending, o_fwd_hit_a, o_fwd_sel_a, o_fwd_hit_b, o_fwd_sel_b
  );

  modport slave (
    input  i_advance, i_issue_valid, i_dst_flag, i_dst, i_flush,
           i_src_a_used, i_src_a, i_src_b_used, i_src_b,
    output o_hazard_a, o_hazard_b, o_stall, o_retire_valid, o_retire_dst,
           o_pending, o_fwd_hit_a, o_fwd_sel_a, o_fwd_hit_b, o_fwd_sel_b
  );
endinterface

// File: rtl/pipe_destination_scoreboard.sv
// Destination scoreboard: shadows DEPTH in-flight stages (entry 0 youngest),
// flags RAW hazards for two source operands, reports retiring writes and
// supports a partial branch flush of the youngest entries.
// Optional macro SCOREBOARD_FWD_HINT_EN builds youngest-producer forwarding
// hints; without it the fwd ports are tied to 0.
module pipe_destination_scoreboard #(
  parameter int DEPTH        = 3,
  parameter int REG_AW       = 3,
  parameter int FLUSH_STAGES = 2
)(
  input logic                          i_clk,
  input logic                          i_rst_n,
  pipe_destination_scoreboard_if.slave sb
);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam bit KILL_ALL = (FLUSH_STAGES == DEPTH);

  logic [DEPTH-1:0]             vld, vld_nxt;
  logic [DEPTH-1:0][REG_AW-1:0] dst, dst_nxt;
  logic [DEPTH-1:0]             match_a, match_b;
  logic [CW-1:0]                cnt;
  logic                         haz_a, haz_b;

  // Next state: shift on advance, then flush the youngest entries on top.
  always_comb begin
    vld_nxt = vld;
    dst_nxt = dst;
    if (sb.i_advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_nxt[k] = vld[k-1];
        dst_nxt[k] = dst[k-1];
      end
      vld_nxt[0] = sb.i_issue_valid & sb.i_dst_flag;
      dst_nxt[0] = (sb.i_issue_valid & sb.i_dst_flag) ? sb.i_dst : '0;
    end
    if (sb.i_flush) begin
      for (int k = 0; k < FLUSH_STAGES; k++) begin
        vld_nxt[k] = 1'b0;
        dst_nxt[k] = '0;
      end
    end
  end

  // State register; reset wins over flush and advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld <= '0;
      dst <= '0;
    end else begin
      vld <= vld_nxt;
      dst <= dst_nxt;
    end
  end

  // Per-entry source compares; the retiring entry still participates.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k] = vld[k] && (dst[k] == sb.i_src_a);
      match_b[k] = vld[k] && (dst[k] == sb.i_src_b);
    end
  end

  // Occupancy count of valid entries.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + CW'(vld[k]);
  end

  // Outputs are forced quiet while reset is asserted.
  assign haz_a             = i_rst_n & sb.i_src_a_used & (|match_a);
  assign haz_b             = i_rst_n & sb.i_src_b_used & (|match_b);
  assign sb.o_hazard_a     = haz_a;
  assign sb.o_hazard_b     = haz_b;
  assign sb.o_stall        = haz_a | haz_b;
  // A full-depth flush also kills the oldest entry, so it never retires.
  assign sb.o_retire_valid = i_rst_n & sb.i_advance & vld[DEPTH-1]
                             & ~(sb.i_flush & KILL_ALL);
  assign sb.o_retire_dst   = (i_rst_n & vld[DEPTH-1]) ? dst[DEPTH-1] : '0;
  assign sb.o_pending      = i_rst_n ? cnt : '0;

`ifdef SCOREBOARD_FWD_HINT_EN
  localparam int SW = $clog2(DEPTH);
  logic [SW-1:0] sel_a, sel_b;

  // Youngest producer wins: scan oldest to youngest so the lowest index sticks.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) sel_a = SW'(k);
      if (match_b[k]) sel_b = SW'(k);
    end
  end

  assign sb.o_fwd_hit_a = haz_a;
  assign sb.o_fwd_hit_b = haz_b;
  assign sb.o_fwd_sel_a = haz_a ? sel_a : '0;
  assign sb.o_fwd_sel_b = haz_b ? sel_b : '0;
`else
  assign sb.o_fwd_hit_a = 1'b0;
  assign sb.o_fwd_hit_b = 1'b0;
  assign sb.o_fwd_sel_a = '0;
  assign sb.o_fwd_sel_b = '0;
`endif
endmodule

// File: tb/tb_pipe_destination_scoreboard.sv
// Bench for pipe_destination_scoreboard (DEPTH=3, REG_AW=3, FLUSH_STAGES=2):
// directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_destination_scoreboard;
  localparam int DEPTH = 3;
  localparam int REG_AW = 3;
  localparam int FS = 2;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct { bit v; int d; } ent_t;
  ent_t pipe[$];

  pipe_destination_scoreboard_if #(.DEPTH(DEPTH), .REG_AW(REG_AW)) bus();

  pipe_destination_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FLUSH_STAGES(FS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (rst_n),
    .sb      (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit adv, input bit iv, input bit flag, input int d,
                       input bit fl, input bit sau, input int sa,
                       input bit sbu, input int sbr);
    bus.i_advance     = adv;
    bus.i_issue_valid = iv;
    bus.i_dst_flag    = flag;
    bus.i_dst         = REG_AW'(d);
    bus.i_flush       = fl;
    bus.i_src_a_used  = sau;
    bus.i_src_a       = REG_AW'(sa);
    bus.i_src_b_used  = sbu;
    bus.i_src_b       = REG_AW'(sbr);
  endtask

  // Youngest pending producer of register r, -1 when none.
  function automatic int producer(input int r);
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].d == r) return k;
    return -1;
  endfunction

  task automatic check_model();
    int pa, pb, pend;
    bit ha, hb, rv;
    int rd, sa_sel, sb_sel;
    pa = producer(int'(bus.i_src_a));
    pb = producer(int'(bus.i_src_b));
    ha = bus.i_src_a_used && pa >= 0;
    hb = bus.i_src_b_used && pb >= 0;
    pend = 0;
    foreach (pipe[k]) if (pipe[k].v) pend++;
    rv = bus.i_advance && pipe[DEPTH-1].v && !(bus.i_flush && FS == DEPTH);
    rd = pipe[DEPTH-1].v ? pipe[DEPTH-1].d : 0;
    sa_sel = ha ? pa : 0;
    sb_sel = hb ? pb : 0;
    if (!rst_n) begin
      ha = 0; hb = 0; rv = 0; rd = 0; pend = 0; sa_sel = 0; sb_sel = 0;
    end
    chk("haz_a", 32'(bus.o_hazard_a), 32'(ha));
    chk("haz_b", 32'(bus.o_hazard_b), 32'(hb));
    chk("stall", 32'(bus.o_stall), 32'(ha | hb));
    chk("ret_v", 32'(bus.o_retire_valid), 32'(rv));
    chk("ret_d", 32'(bus.o_retire_dst), 32'(rd));
    chk("pend", 32'(bus.o_pending), 32'(pend));
`ifdef SCOREBOARD_FWD_HINT_EN
    chk("fhit_a", 32'(bus.o_fwd_hit_a), 32'(ha));
    chk("fsel_a", 32'(bus.o_fwd_sel_a), 32'(sa_sel));
    chk("fhit_b", 32'(bus.o_fwd_hit_b), 32'(hb));
    chk("fsel_b", 32'(bus.o_fwd_sel_b), 32'(sb_sel));
`else
    chk("fhit_a", 32'(bus.o_fwd_hit_a), 32'd0);
    chk("fsel_a", 32'(bus.o_fwd_sel_a), 32'd0);
    chk("fhit_b", 32'(bus.o_fwd_hit_b), 32'd0);
    chk("fsel_b", 32'(bus.o_fwd_sel_b), 32'd0);
`endif
  endtask

  task automatic update_model();
    ent_t e;
    if (!rst_n) begin
      foreach (pipe[k]) pipe[k] = '{v: 1'b0, d: 0};
      return;
    end
    if (bus.i_advance) begin
      void'(pipe.pop_back());
      e.v = bus.i_issue_valid && bus.i_dst_flag;
      e.d = e.v ? int'(bus.i_dst) : 0;
      pipe.push_front(e);
    end
    if (bus.i_flush)
      for (int k = 0; k < FS; k++) pipe[k] = '{v: 1'b0, d: 0};
  endtask

  // One clock: check against model mid-cycle, then advance model at the edge.
  task automatic tick();
    @(negedge i_clk);
    check_model();
    @(posedge i_clk);
    update_model();
    #1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) pipe.push_back('{v: 1'b0, d: 0});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // 1: fill, then one reset edge with advance held high.
    for (int i = 1; i <= 3; i++) begin drive(1, 1, 1, i, 0, 0, 0, 0, 0); tick(); end
    chk("t1_full", 32'(bus.o_pending), 32'd3);
    rst_n = 1'b0;
    drive(1, 1, 1, 4, 0, 1, 1, 1, 2);
    tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 1, 1, 2);
    #1;
    chk("t1_pend", 32'(bus.o_pending), 32'd0);
    chk("t1_haz", 32'(bus.o_hazard_a | bus.o_hazard_b), 32'd0);
    chk("t1_ret", 32'(bus.o_retire_valid), 32'd0);
    tick();

    // 2: dst 5 hazards operand A for three cycles, retires on the third.
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_haz", 32'(bus.o_hazard_a), 32'd1);
      chk("t2_stall", 32'(bus.o_stall), 32'd1);
      chk("t2_ret", 32'(bus.o_retire_valid), 32'(c == 2));
      if (c == 2) chk("t2_rdst", 32'(bus.o_retire_dst), 32'd5);
      tick();
    end
    #1;
    chk("t2_clear", 32'(bus.o_hazard_a), 32'd0);

    // 3: stall holds the entry; retire three advances after issue.
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 6, 0, 0, 0, 1, 3);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_haz", 32'(bus.o_hazard_b), 32'd1);
      chk("t3_pend", 32'(bus.o_pending), 32'd1);
      chk("t3_ret", 32'(bus.o_retire_valid), 32'd0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_rv", 32'(bus.o_retire_valid), 32'(c == 2));
      tick();
    end

    // 4: flush with advance and issue keeps only the shifted oldest survivor.
    drive(1, 1, 1, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 7, 1, 0, 0, 0, 0);
    #1;
    chk("t4_rv", 32'(bus.o_retire_valid), 32'd1);
    chk("t4_rd", 32'(bus.o_retire_dst), 32'd6);
    tick();
    drive(1, 0, 0, 0, 0, 1, 4, 1, 7);
    #1;
    chk("t4_pend", 32'(bus.o_pending), 32'd1);
    chk("t4_haz4", 32'(bus.o_hazard_a), 32'd1);
    chk("t4_haz7", 32'(bus.o_hazard_b), 32'd0);
    chk("t4_rd4", 32'(bus.o_retire_dst), 32'd4);
    tick();

    // 5: non-writing instruction leaves no pending destination.
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    #1;
    chk("t5_haz", 32'(bus.o_hazard_a), 32'd0);
    chk("t5_pend", 32'(bus.o_pending), 32'd0);
    tick();

    // 6: same dst in entries 0 and 2; youngest producer is selected.
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 2, 1, 5);
    #1;
    chk("t6_haz", 32'(bus.o_hazard_a), 32'd1);
`ifdef SCOREBOARD_FWD_HINT_EN
    chk("t6_hit", 32'(bus.o_fwd_hit_a), 32'd1);
    chk("t6_sel", 32'(bus.o_fwd_sel_a), 32'd0);
    chk("t6_selb", 32'(bus.o_fwd_sel_b), 32'd1);
`else
    chk("t6_hit", 32'(bus.o_fwd_hit_a), 32'd0);
    chk("t6_sel", 32'(bus.o_fwd_sel_a), 32'd0);
`endif
    tick();

    // Randomized traffic, occasional resets and flushes.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            ($urandom_range(0, 11) == 0), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
